// File: rtl/uart_boot_ctrl_if.sv
// Byte stream from UART RX, ack byte to UART TX and the instruction-memory write port.
// The boot controller drives this interface as master.
interface uart_boot_ctrl_if #(
    parameter int ADDR_W = 8
) ();
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/uart_boot_ctrl.sv
// UART boot sequencer: parses SYNC/LEN/payload/CSUM frames, writes little-endian words
// to instruction memory from address 0, acks 'K' or 'E' and holds the core in reset until loaded.
module uart_boot_ctrl #(
    parameter int          ADDR_W  = 8,
    parameter int          DEPTH   = 256,
    parameter int          TIMEOUT = 1_000_000,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    uart_boot_ctrl_if.master bus,
    output logic            cpu_rst,
    output logic            boot_done,
    output logic            boot_err
);
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_ACK_OK, S_ERR, S_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       wbuf_q, wbuf_d;
    logic [7:0]        csum_q, csum_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              boot_done_q, boot_done_d;
    logic              boot_err_q, boot_err_d;

    logic [31:0] word;
    logic [15:0] len_new;
    logic        timed, sync_hit, err_entry, handshake;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wcnt_d      = wcnt_q;
        byte_cnt_d  = byte_cnt_q;
        wbuf_d      = wbuf_q;
        csum_d      = csum_q;
        to_d        = '0;
        addr_d      = addr_q;
        we_d        = 1'b0;
        wdata_d     = wdata_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        cpu_rst_d   = cpu_rst_q;
        boot_done_d = boot_done_q;
        boot_err_d  = boot_err_q;
        sync_hit    = 1'b0;
        err_entry   = 1'b0;
        handshake   = tx_valid_q && bus.tx_ready;
        len_new     = {bus.rx_data, len_q[7:0]};
        word        = wbuf_q;
        word[{byte_cnt_q, 3'b000} +: 8] = bus.rx_data;

        // Address advances in the cycle after the write so it is stable during imem_we.
        if (we_q) addr_d = addr_q + ADDR_W'(1);

        timed = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                (state_q == S_DATA) || (state_q == S_CSUM);
        if (timed && !bus.rx_valid) to_d = to_q + TO_W'(1);

        case (state_q)
            S_IDLE: if (bus.rx_valid && bus.rx_data == SYNC) sync_hit = 1'b1;
            S_RUN: begin
                if (bus.rx_valid && bus.rx_data == SYNC) begin
                    sync_hit    = 1'b1;
                    cpu_rst_d   = 1'b1;
                    boot_done_d = 1'b0;
                end
            end
            S_LEN0: begin
                if (bus.rx_valid) begin
                    len_d[7:0] = bus.rx_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (bus.rx_valid) begin
                    len_d = len_new;
                    if (32'(len_new) > DEPTH) err_entry = 1'b1;
                    else if (len_new == 16'd0) state_d = S_CSUM;
                    else state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    csum_d     = csum_q ^ bus.rx_data;
                    wbuf_d     = word;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = word;
                        wcnt_d  = wcnt_q + 16'd1;
                        if (wcnt_q == len_q - 16'd1) state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == csum_q) begin
                        state_d    = S_ACK_OK;
                        tx_valid_d = 1'b1;
                        tx_data_d  = 8'h4B;
                    end else begin
                        err_entry = 1'b1;
                    end
                end
            end
            S_ACK_OK: begin
                if (handshake) begin
                    tx_valid_d  = 1'b0;
                    state_d     = S_RUN;
                    cpu_rst_d   = 1'b0;
                    boot_done_d = 1'b1;
                end
            end
            S_ERR: begin
                if (handshake) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timed && !bus.rx_valid && to_q == TO_W'(TIMEOUT - 1)) err_entry = 1'b1;

        if (sync_hit) begin
            state_d    = S_LEN0;
            boot_err_d = 1'b0;
            csum_d     = '0;
            addr_d     = '0;
            wcnt_d     = '0;
            byte_cnt_d = '0;
        end

        if (err_entry) begin
            state_d    = S_ERR;
            boot_err_d = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = 8'h45;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            wcnt_q      <= '0;
            byte_cnt_q  <= '0;
            wbuf_q      <= '0;
            csum_q      <= '0;
            to_q        <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            cpu_rst_q   <= 1'b1;
            boot_done_q <= 1'b0;
            boot_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wcnt_q      <= wcnt_d;
            byte_cnt_q  <= byte_cnt_d;
            wbuf_q      <= wbuf_d;
            csum_q      <= csum_d;
            to_q        <= to_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            cpu_rst_q   <= cpu_rst_d;
            boot_done_q <= boot_done_d;
            boot_err_q  <= boot_err_d;
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_rst        = cpu_rst_q;
    assign boot_done      = boot_done_q;
    assign boot_err       = boot_err_q;
endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Randomized frame-level bench for uart_boot_ctrl against a byte/word reference model.
module tb_uart_boot_ctrl;
    localparam int ADDR_W  = 8;
    localparam int DEPTH   = 256;
    localparam int TIMEOUT = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_rst, boot_done, boot_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] pay_q[$];
    logic [39:0] wr_log[$];

    uart_boot_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    uart_boot_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT),
        .SYNC   (8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cpu_rst  (cpu_rst),
        .boot_done(boot_done),
        .boot_err (boot_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.imem_we === 1'b1) wr_log.push_back({bus.imem_addr, bus.imem_wdata});

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cpu_rst"},   40'(cpu_rst),        40'd1);
        check_eq({tag, "_boot_done"}, 40'(boot_done),      40'd0);
        check_eq({tag, "_boot_err"},  40'(boot_err),       40'd0);
        check_eq({tag, "_we"},        40'(bus.imem_we),    40'd0);
        check_eq({tag, "_addr"},      40'(bus.imem_addr),  40'd0);
        check_eq({tag, "_wdata"},     40'(bus.imem_wdata), 40'd0);
        check_eq({tag, "_tx_valid"},  40'(bus.tx_valid),   40'd0);
        check_eq({tag, "_tx_data"},   40'(bus.tx_data),    40'd0);
    endtask

    // Waits (bounded) for the ack, optionally stalls tx_ready, then completes the handshake.
    task automatic wait_ack(input logic [7:0] exp_ch, input int exp_lat, input int stall,
                            input string tag);
        int lat = 0;
        while (bus.tx_valid !== 1'b1 && lat < 300) begin
            tick();
            lat++;
        end
        check_eq({tag, "_ack_latency"}, 40'(lat), 40'(exp_lat));
        if (bus.tx_valid !== 1'b1) return;
        check_eq({tag, "_tx_data"}, 40'(bus.tx_data), 40'(exp_ch));
        for (int i = 0; i < stall; i++) begin
            tick();
            check_eq({tag, "_stall_valid"},   40'(bus.tx_valid), 40'd1);
            check_eq({tag, "_stall_data"},    40'(bus.tx_data),  40'(exp_ch));
            check_eq({tag, "_stall_cpu_rst"}, 40'(cpu_rst),      40'd1);
        end
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        check_eq({tag, "_tx_valid_after"}, 40'(bus.tx_valid), 40'd0);
        if (exp_ch == 8'h4B) begin
            check_eq({tag, "_cpu_rst"},   40'(cpu_rst),   40'd0);
            check_eq({tag, "_boot_done"}, 40'(boot_done), 40'd1);
            check_eq({tag, "_boot_err"},  40'(boot_err),  40'd0);
        end else begin
            check_eq({tag, "_cpu_rst"},   40'(cpu_rst),   40'd1);
            check_eq({tag, "_boot_done"}, 40'(boot_done), 40'd0);
            check_eq({tag, "_boot_err"},  40'(boot_err),  40'd1);
        end
    endtask

    // Builds a frame from pay_q, sends it and checks writes and ack against the model.
    task automatic run_frame(input logic [15:0] len, input bit bad, input bit gaps,
                             input int stall, input string tag);
        logic [7:0] bytes[$];
        logic [7:0] cs;
        logic [7:0] w;
        logic [31:0] wd;
        bit ok;
        int exp_n;
        bytes = {};
        cs = 8'h00;
        bytes.push_back(8'hA5);
        bytes.push_back(len[7:0]);
        bytes.push_back(len[15:8]);
        if (int'(len) <= DEPTH) begin
            for (int i = 0; i < int'(len); i++) begin
                wd = pay_q[i];
                for (int b = 0; b < 4; b++) begin
                    w = wd[8*b +: 8];
                    bytes.push_back(w);
                    cs ^= w;
                end
            end
            bytes.push_back(bad ? (cs ^ 8'h01) : cs);
        end
        ok    = (int'(len) <= DEPTH) && !bad;
        exp_n = (int'(len) <= DEPTH) ? int'(len) : 0;
        wr_log.delete();

        send_byte(bytes[0]);
        check_eq({tag, "_sync_cpu_rst"},   40'(cpu_rst),   40'd1);
        check_eq({tag, "_sync_boot_done"}, 40'(boot_done), 40'd0);
        check_eq({tag, "_sync_boot_err"},  40'(boot_err),  40'd0);
        for (int i = 1; i < bytes.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            send_byte(bytes[i]);
        end
        wait_ack(ok ? 8'h4B : 8'h45, 0, stall, tag);

        check_eq({tag, "_num_writes"}, 40'(wr_log.size()), 40'(exp_n));
        for (int i = 0; i < exp_n && i < wr_log.size(); i++)
            check_eq({tag, "_write"}, wr_log[i], {i[7:0], pay_q[i]});
    endtask

    initial begin
        logic [7:0] b;
        int n;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check_reset_outputs("post_reset");

        // Valid 2-word image from the reference frame (checksum D0).
        pay_q = {32'h00000013, 32'h00500093};
        run_frame(16'd2, 1'b0, 1'b0, 0, "valid2");

        // Non-SYNC bytes in RUN are ignored.
        wr_log.delete();
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b);
        end
        repeat (3) tick();
        check_eq("run_noise_cpu_rst",   40'(cpu_rst),        40'd0);
        check_eq("run_noise_boot_done", 40'(boot_done),      40'd1);
        check_eq("run_noise_tx_valid",  40'(bus.tx_valid),   40'd0);
        check_eq("run_noise_writes",    40'(wr_log.size()),  40'd0);

        // Bad checksum (D1), then recovery with a good frame.
        run_frame(16'd2, 1'b1, 1'b0, 0, "bad_csum");
        send_byte(8'h3C);
        tick();
        check_eq("idle_after_err_tx_valid", 40'(bus.tx_valid), 40'd0);
        run_frame(16'd2, 1'b0, 1'b1, 0, "recover");

        // Oversize length: error right after LEN_HI, no writes.
        run_frame(16'h0101, 1'b0, 1'b0, 0, "oversize");

        // Exactly DEPTH words, back-to-back.
        pay_q = {};
        for (int i = 0; i < DEPTH; i++) pay_q.push_back($urandom);
        run_frame(16'(DEPTH), 1'b0, 1'b0, 0, "full_depth");

        // Timeout inside DATA.
        wr_log.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h12);
        wait_ack(8'h45, TIMEOUT, 0, "timeout");
        check_eq("timeout_writes", 40'(wr_log.size()), 40'd0);

        // Empty image from RUN: load, then reprogram with A5 00 00 00.
        pay_q = {32'hDEADBEEF};
        run_frame(16'd1, 1'b0, 1'b0, 0, "pre_reprog");
        run_frame(16'd0, 1'b0, 1'b0, 0, "reprog_empty");

        // Randomized frames with random inter-byte gaps.
        for (int f = 0; f < 10; f++) begin
            n = $urandom_range(0, 6);
            pay_q = {};
            for (int i = 0; i < n; i++) pay_q.push_back($urandom);
            run_frame(16'(n), ($urandom_range(0, 3) == 0), 1'b1, 0, "random");
        end

        // Reset in the middle of DATA, after one word was written.
        pay_q = {32'h11223344, 32'h55667788, 32'h99AABBCC, 32'h01020304};
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h00);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("mid_data_reset");
        repeat (TIMEOUT + 20) tick();
        check_eq("idle_no_timeout", 40'(bus.tx_valid), 40'd0);

        // tx_ready stalled for 50 cycles during ACK_OK.
        run_frame(16'd4, 1'b0, 1'b1, 50, "stall");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
